legv8_alu_arbiter: RTL
======================

Name: legv8_alu_arbiter

Overview:
Shares one LEGv8 ALU between two requesters: port 0 is the pipeline EX stage, port 1 is the address/branch-target unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin, or fixed-priority when configured. Execution is a 2-stage pipeline with a one-deep response buffer per requester.

Parameters:
DATA_W, 64, operand/result width
FIXED_PRIO, 0, 1 = port 0 always wins contention; 0 = round-robin

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle when high with valid
req0_ctrl  in  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, PASS-B 0111, NOR 1100
req0_a  in  DATA_W  operand 1
req0_b  in  DATA_W  operand 2
rsp0_valid  out  1  port 0 result available
rsp0_ready  in  1  port 0 consumer accepts result
rsp0_result  out  DATA_W  ALU result
rsp0_zero  out  1  result == 0
rsp0_err  out  1  ctrl was not a legal encoding
req1_*, rsp1_*  same set for port 1
busy  out  1  issue stage or any response buffer occupied

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Issue stage, both response buffers and pending flags cleared.
  - Round-robin pointer set to "last granted = 1", so port 0 wins the first contention.
  - Any in-flight op is discarded with no response.
- Eligibility of port i: pending_i == 0 AND (rsp_i buffer empty OR rspi_valid && rspi_ready this cycle).
  - pending_i is set on accept and cleared when that op's result is written to the buffer.
  - Each port therefore has at most 1 op outstanding.
- Grant:
  - One valid eligible port: it is granted.
  - Both valid and eligible: FIXED_PRIO=1 grants port 0; otherwise the port not granted last.
  - Pointer updates only on an actual grant.
  - reqi_ready = grant_i (combinational from valid, eligibility, pointer).
  - A ready with no valid never occurs: ready is only asserted for a valid, eligible port.
- Stage 1 (accept edge, cycle N): issue register latches ctrl, a, b, port id and valid.
- Stage 2 (cycle N+1):
  - ALU evaluates combinationally from the issue register.
  - At the end of N+1 the result, zero and err are written to port id's buffer.
  - rspi_valid is high from cycle N+2. Latency = 2 cycles.
- Throughput: 1 op/cycle total with both ports active (interleaved); 1 op per 2 cycles for a single port.
- Response hold: rspi_valid/result/zero/err stay stable until rspi_ready is sampled high; the buffer then empties.
  - Write and drain in the same cycle is legal only via the eligibility rule. The new result overwrites the drained slot.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W, no carry/overflow output.
  - NOR is bitwise ~(a|b). PASS-B outputs b.
  - zero is computed on the final registered result.
- Illegal ctrl: result = 0, zero = 1, err = 1. The op still completes normally and consumes one slot.
- Simultaneous accept on one port and drain on the other are independent.
- busy is high when the issue stage is valid OR either rspi_valid is high.

Decomposition:
- Shared package legv8_alu_pkg holds:
  - ALU op encodings (AND/OR/ADD/SUB/PIB/NOR) as localparams.
  - An is_legal_op function.
  - The DATA_W default.
- Sub-modules:
  - legv8_rr_arb2: two-request round-robin picker with FIXED_PRIO; inputs request vector and grant-enable, outputs one-hot grant and pointer.
  - The team's LEGv8_ALU module, instanced once and fed from the issue register.

Test Plan:
- Single op: port 0 ADD a=5, b=7 accepted at cycle 0 -> rsp0_valid at cycle 2, result 12, zero 0, err 0; req0_ready low in cycle 1.
- Contention: both ports valid every cycle with rsp_ready=1 -> grants alternate 0,1,0,1, one result per cycle after fill. With FIXED_PRIO=1, port 0 gets every eligible cycle and port 1 only the gaps.
- Backpressure: port 1 SUB a=9, b=9 with rsp1_ready=0 for 5 cycles:
  - result 0, zero 1, held stable throughout.
  - req1_ready stays low while the buffer is full.
  - Port 0 keeps issuing unaffected.
  - Releasing rsp1_ready allows a new port 1 accept in that same cycle.
- Op coverage: NOR a=0, b=0 -> all-ones, zero 0. PIB b=0xDEAD -> 0xDEAD. SUB 0-1 -> 0xFFFF_FFFF_FFFF_FFFF. AND 0xF0 & 0x0F -> 0, zero 1.
- Illegal ctrl 4'b1111 -> result 0, zero 1, err 1, after the normal 2-cycle latency.
- Reset mid-flight: assert rst_n=0 asynchronously the cycle after an accept -> all outputs 0 immediately and no response after release. The first contention afterwards is granted to port 0.

Source files
------------

// File: rtl/legv8_alu_pkg.sv
// Shared LEGv8 ALU definitions: op encodings, default width and a legality check.
package legv8_alu_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NUM_PORTS  = 2;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_AND = 4'b0000;
  localparam alu_op_t OP_OR  = 4'b0001;
  localparam alu_op_t OP_ADD = 4'b0010;
  localparam alu_op_t OP_SUB = 4'b0110;
  localparam alu_op_t OP_PIB = 4'b0111;
  localparam alu_op_t OP_NOR = 4'b1100;

  function automatic logic is_legal_op(input alu_op_t op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PIB, OP_NOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/legv8_alu_arbiter_if.sv
// One requester's request and response channels into the shared ALU.
interface legv8_alu_arbiter_if #(
  parameter int DATA_W = legv8_alu_pkg::DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_ctrl;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req_valid, req_ctrl, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/LEGv8_ALU.sv
// Combinational LEGv8 ALU; unknown op codes produce a zero result.
module LEGv8_ALU
  import legv8_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  alu_op_t           i_ctrl,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_PIB:  o_result = i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);
endmodule

// File: rtl/legv8_rr_arb2.sv
// Two-way round-robin picker; FIXED_PRIO makes requester 0 win every contention.
module legv8_rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant,
  output logic       o_last
);
  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (FIXED_PRIO || r_last) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Reset to "last = 1" so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= o_grant[1];
    end
  end

  assign o_last = r_last;
endmodule

// File: rtl/legv8_alu_arbiter.sv
// Shares one LEGv8 ALU between the EX stage (port 0) and the address unit (port 1):
// arbitrate, issue register, ALU, then a one-deep response buffer per port.
module legv8_alu_arbiter
  import legv8_alu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  legv8_alu_arbiter_if.slave if_port0,
  legv8_alu_arbiter_if.slave if_port1,
  output logic               o_busy
);
  logic [1:0]        w_req_valid;
  logic [1:0]        w_rsp_ready;
  logic [1:0]        w_pending;
  logic [1:0]        w_elig;
  logic [1:0]        w_grant;
  alu_op_t           w_req_ctrl [NUM_PORTS];
  logic [DATA_W-1:0] w_req_a    [NUM_PORTS];
  logic [DATA_W-1:0] w_req_b    [NUM_PORTS];
  logic              w_rr_last;

  logic              r_iss_valid;
  alu_op_t           r_iss_ctrl;
  logic [DATA_W-1:0] r_iss_a;
  logic [DATA_W-1:0] r_iss_b;

  logic [1:0]        r_rsp_valid;
  logic [1:0]        r_rsp_zero;
  logic [1:0]        r_rsp_err;
  logic [DATA_W-1:0] r_rsp_result [NUM_PORTS];

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;
  logic              w_alu_err;

  assign w_req_valid   = {if_port1.req_valid, if_port0.req_valid};
  assign w_rsp_ready   = {if_port1.rsp_ready, if_port0.rsp_ready};
  assign w_req_ctrl[0] = if_port0.req_ctrl;
  assign w_req_ctrl[1] = if_port1.req_ctrl;
  assign w_req_a[0]    = if_port0.req_a;
  assign w_req_a[1]    = if_port1.req_a;
  assign w_req_b[0]    = if_port0.req_b;
  assign w_req_b[1]    = if_port1.req_b;

  // The issue register always holds the most recent grant, so the arbiter's
  // last-granted pointer doubles as the issuing port id.
  assign w_pending = r_iss_valid ? (w_rr_last ? 2'b10 : 2'b01) : 2'b00;
  assign w_elig    = ~w_pending & (~r_rsp_valid | w_rsp_ready);

  legv8_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_req_valid & w_elig),
    .i_en    (rst_n),
    .o_grant (w_grant),
    .o_last  (w_rr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss_ctrl  <= OP_AND;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
    end else begin
      r_iss_valid <= |w_grant;
      if (|w_grant) begin
        r_iss_ctrl <= w_grant[1] ? w_req_ctrl[1] : w_req_ctrl[0];
        r_iss_a    <= w_grant[1] ? w_req_a[1]    : w_req_a[0];
        r_iss_b    <= w_grant[1] ? w_req_b[1]    : w_req_b[0];
      end
    end
  end

  LEGv8_ALU #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_ctrl   (r_iss_ctrl),
    .i_a      (r_iss_a),
    .i_b      (r_iss_b),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign w_alu_err = !is_legal_op(r_iss_ctrl);

  // A write takes priority over a drain: eligibility only lets a port issue
  // into a full buffer when that buffer is being drained the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid     <= '0;
      r_rsp_zero      <= '0;
      r_rsp_err       <= '0;
      r_rsp_result[0] <= '0;
      r_rsp_result[1] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_pending[i]) begin
          r_rsp_valid[i]  <= 1'b1;
          r_rsp_result[i] <= w_alu_result;
          r_rsp_zero[i]   <= w_alu_zero;
          r_rsp_err[i]    <= w_alu_err;
        end else if (w_rsp_ready[i]) begin
          r_rsp_valid[i]  <= 1'b0;
        end
      end
    end
  end

  assign if_port0.req_ready  = w_grant[0];
  assign if_port1.req_ready  = w_grant[1];
  assign if_port0.rsp_valid  = r_rsp_valid[0];
  assign if_port1.rsp_valid  = r_rsp_valid[1];
  assign if_port0.rsp_result = r_rsp_result[0];
  assign if_port1.rsp_result = r_rsp_result[1];
  assign if_port0.rsp_zero   = r_rsp_zero[0];
  assign if_port1.rsp_zero   = r_rsp_zero[1];
  assign if_port0.rsp_err    = r_rsp_err[0];
  assign if_port1.rsp_err    = r_rsp_err[1];

  assign o_busy = r_iss_valid | (|r_rsp_valid);
endmodule
